fraction_reducer: RTL and testbench
===================================

Name: fraction_reducer

Overview:
- Accepts a fraction num/den over a valid/ready handshake.
- Computes g = gcd(num, den) iteratively and returns the reduced fraction num/g, den/g together with g.
- Sits downstream of operand sources as the consumer/initiator side of the team's GCD datapath. Results are delivered over a second valid/ready handshake.
- Binary GCD (Stein) followed by a shared restoring divider. One fraction is in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).

Ports:
- clk  input  1  clock, all state changes on rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE and clears all outputs.
- in_valid  input  1  source presents num/den.
- in_ready  output  1  block can accept; high only in IDLE.
- num  input  WIDTH  numerator, unsigned.
- den  input  WIDTH  denominator, unsigned.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  sink accepts result.
- num_red  output  WIDTH  num / g.
- den_red  output  WIDTH  den / g.
- gcd_out  output  WIDTH  g.
- err  output  1  den was zero; qualified by out_valid.

Behaviour:
- Reset values: in_ready=0 while reset is asserted, then 1 in IDLE. out_valid=0, num_red=0, den_red=0, gcd_out=0, err=0. State=IDLE.
- Input transfer: in_valid & in_ready on a rising edge. num/den are latched into internal registers; later input changes are ignored.
- States: IDLE, GCD, DIV_NUM, DIV_DEN, DONE.
- IDLE, on transfer:
  - den==0 → DONE with err=1 and num_red=den_red=gcd_out=0.
  - num==0 → DONE with g=den, num_red=0, den_red=1, err=0.
  - Otherwise → GCD, with a=num, b=den, shift count k=0.
- GCD, one step per cycle, priority order:
  - a==b → g = a<<k, go to DIV_NUM (or DONE if g==1).
  - a and b both even → a>>=1, b>>=1, k++.
  - a even → a>>=1.
  - b even → b>>=1.
  - else → larger := larger − smaller.
  - k never exceeds WIDTH−1. Arithmetic is WIDTH-bit unsigned and no intermediate exceeds its starting value.
- DIV_NUM / DIV_DEN:
  - Restoring division of the latched operand by g, one quotient bit per cycle, exactly WIDTH cycles each.
  - Quotient goes to num_red / den_red respectively. The remainder must be zero; it is not output.
  - One divider is shared by both phases.
- g==1 shortcut: skip both divide states; num_red=num, den_red=den.
- DONE:
  - out_valid=1 and all result outputs stable.
  - On out_valid & out_ready → IDLE, out_valid=0 next cycle.
  - Result outputs keep their last values in IDLE until the next result.
- Latency from input transfer to out_valid:
  - Special cases (den==0 or num==0): 1 cycle.
  - Otherwise: ≤ 2·WIDTH+1 GCD cycles + 2·WIDTH divide cycles + 1.
- No new input is accepted until the current result has been taken. The earliest in_ready is the cycle after the out_valid & out_ready transfer.
- Reset mid-operation: immediate abort to IDLE, all outputs cleared, partial result discarded. No spurious out_valid after reset is released.
- in_valid while busy: ignored. The source must hold in_valid until in_ready.

Test Plan:
- num=48, den=18 → out_valid with gcd_out=6, num_red=8, den_red=3, err=0, within latency bound.
- num=0, den=5 → one cycle after transfer: gcd_out=5, num_red=0, den_red=1, err=0.
- num=7, den=0 → err=1, num_red=den_red=gcd_out=0. Next fraction num=17, den=13 → gcd_out=1, num_red=17, den_red=13, divide states skipped.
- num=den=0xFFFFFFFF → gcd_out=0xFFFFFFFF, num_red=den_red=1. num=0x80000000, den=0x40000000 → gcd_out=0x40000000, num_red=2, den_red=1.
- Backpressure: num=100, den=75, out_ready held low 20 cycles → out_valid and outputs (g=25, 4/3) stable throughout, in_ready=0. Raise out_ready → transfer, in_ready=1 next cycle.
- Assert reset for 2 cycles during DIV_NUM of num=48, den=18 → all outputs 0, IDLE. Then num=84, den=36 → gcd_out=12, num_red=7, den_red=3.

Source files
------------

// File: rtl/fraction_reducer.sv
// Reduces num/den by their GCD: binary (Stein) GCD, then a shared
// restoring divider produces num/g and den/g, one fraction at a time.
module fraction_reducer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] num_red,
    output logic [WIDTH-1:0] den_red,
    output logic [WIDTH-1:0] gcd_out,
    output logic             err
);

    localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GCD,
        S_DIV_NUM,
        S_DIV_DEN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_num;
    logic [WIDTH-1:0] r_den;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_qnum;
    logic [WIDTH-1:0] r_num_red;
    logic [WIDTH-1:0] r_den_red;
    logic [WIDTH-1:0] r_gcd;
    logic             r_err;
    logic             r_out_valid;

    logic             w_xfer;
    logic             w_eq;
    logic [WIDTH-1:0] w_g;
    logic             w_g_one;
    logic             w_last;
    logic [WIDTH-1:0] w_a_nx;
    logic [WIDTH-1:0] w_b_nx;
    logic [KW-1:0]    w_k_nx;
    logic [WIDTH:0]   w_div_shift;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;

    assign in_ready  = (r_state == S_IDLE) & ~reset;
    assign out_valid = r_out_valid;
    assign num_red   = r_num_red;
    assign den_red   = r_den_red;
    assign gcd_out   = r_gcd;
    assign err       = r_err;

    assign w_xfer  = in_valid & in_ready;
    assign w_eq    = (r_a == r_b);
    assign w_g     = r_a << r_k;
    assign w_g_one = (w_g == ONE);
    assign w_last  = (r_cnt == CNT_LAST);

    // Remainder stays below g, so a borrow out of the top bit means "no fit".
    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_g};
    assign w_div_ge    = ~w_div_diff[WIDTH];
    assign w_div_rem   = w_div_ge ? w_div_diff[WIDTH-1:0]
                                  : w_div_shift[WIDTH-1:0];
    assign w_div_quo   = {r_quo[WIDTH-2:0], w_div_ge};

    always_comb begin
        w_a_nx = r_a;
        w_b_nx = r_b;
        w_k_nx = r_k;
        if (!r_a[0] && !r_b[0]) begin
            w_a_nx = r_a >> 1;
            w_b_nx = r_b >> 1;
            w_k_nx = r_k + 1'b1;
        end else if (!r_a[0]) begin
            w_a_nx = r_a >> 1;
        end else if (!r_b[0]) begin
            w_b_nx = r_b >> 1;
        end else if (r_a > r_b) begin
            w_a_nx = r_a - r_b;
        end else begin
            w_b_nx = r_b - r_a;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    if (den == '0 || num == '0) w_next = S_DONE;
                    else                        w_next = S_GCD;
                end
            end
            S_GCD: begin
                if (w_eq) w_next = w_g_one ? S_DONE : S_DIV_NUM;
            end
            S_DIV_NUM: begin
                if (w_last) w_next = S_DIV_DEN;
            end
            S_DIV_DEN: begin
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num       <= '0;
            r_den       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_k         <= '0;
            r_g         <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_qnum      <= '0;
            r_num_red   <= '0;
            r_den_red   <= '0;
            r_gcd       <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_num <= num;
                        r_den <= den;
                        r_a   <= num;
                        r_b   <= den;
                        r_k   <= '0;
                        if (den == '0) begin
                            r_num_red   <= '0;
                            r_den_red   <= '0;
                            r_gcd       <= '0;
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                        end else if (num == '0) begin
                            r_num_red   <= '0;
                            r_den_red   <= ONE;
                            r_gcd       <= den;
                            r_err       <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_GCD: begin
                    if (w_eq) begin
                        r_g   <= w_g;
                        r_rem <= '0;
                        r_quo <= r_num;
                        r_cnt <= '0;
                        if (w_g_one) begin
                            r_num_red   <= r_num;
                            r_den_red   <= r_den;
                            r_gcd       <= ONE;
                            r_err       <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end else begin
                        r_a <= w_a_nx;
                        r_b <= w_b_nx;
                        r_k <= w_k_nx;
                    end
                end
                S_DIV_NUM: begin
                    r_rem <= w_div_rem;
                    r_quo <= w_div_quo;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_qnum <= w_div_quo;
                        r_rem  <= '0;
                        r_quo  <= r_den;
                        r_cnt  <= '0;
                    end
                end
                S_DIV_DEN: begin
                    r_rem <= w_div_rem;
                    r_quo <= w_div_quo;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_num_red   <= r_qnum;
                        r_den_red   <= w_div_quo;
                        r_gcd       <= r_g;
                        r_err       <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_fraction_reducer.sv
// Directed bench for fraction_reducer: scoreboard of expected results,
// immediate-assertion checks on each output.
module tb_fraction_reducer;

    localparam int W = 32;
    localparam int MAXLAT = 4 * W + 2;

    typedef struct packed {
        logic [W-1:0] nr;
        logic [W-1:0] dr;
        logic [W-1:0] g;
        logic         e;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] num_red;
    logic [W-1:0] den_red;
    logic [W-1:0] gcd_out;
    logic         err;

    int   n_cmp;
    int   n_fail;
    exp_t sb[$];

    fraction_reducer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .num      (num),
        .den      (den),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .num_red  (num_red),
        .den_red  (den_red),
        .gcd_out  (gcd_out),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0b expected %0b", tag, got, exp);
        end
    endtask

    task automatic check_le(input string tag, input int got, input int lim);
        n_cmp++;
        assert (got <= lim) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected <= %0d", tag, got, lim);
        end
    endtask

    task automatic send(input logic [W-1:0] n, input logic [W-1:0] d,
                        input logic [W-1:0] enr, input logic [W-1:0] edr,
                        input logic [W-1:0] eg, input logic ee);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        check1("in_ready_before_send", in_ready, 1'b1);
        e.nr = enr;
        e.dr = edr;
        e.g  = eg;
        e.e  = ee;
        sb.push_back(e);
        in_valid = 1'b1;
        num = n;
        den = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        num = $urandom;
        den = $urandom;
    endtask

    task automatic receive(input string tag, input int lim, input bit exact,
                           input int hold);
        int   lat;
        exp_t e;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < lim + 5) begin
            @(negedge clk);
            lat++;
        end
        check1({tag, "_out_valid"}, out_valid, 1'b1);
        if (exact) check({tag, "_latency"}, W'(lat), W'(lim));
        else       check_le({tag, "_latency"}, lat, lim);
        if (sb.size() == 0) begin
            check1({tag, "_sb_nonempty"}, 1'b0, 1'b1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        check({tag, "_gcd"}, gcd_out, e.g);
        check({tag, "_num_red"}, num_red, e.nr);
        check({tag, "_den_red"}, den_red, e.dr);
        check1({tag, "_err"}, err, e.e);
        check1({tag, "_in_ready_busy"}, in_ready, 1'b0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check1({tag, "_hold_valid"}, out_valid, 1'b1);
            check1({tag, "_hold_in_ready"}, in_ready, 1'b0);
            check({tag, "_hold_gcd"}, gcd_out, e.g);
            check({tag, "_hold_num"}, num_red, e.nr);
            check({tag, "_hold_den"}, den_red, e.dr);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check1({tag, "_valid_drop"}, out_valid, 1'b0);
        check1({tag, "_in_ready_after"}, in_ready, 1'b1);
        check({tag, "_idle_keep_gcd"}, gcd_out, e.g);
        check({tag, "_idle_keep_num"}, num_red, e.nr);
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        num       = '0;
        den       = '0;
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check1("rst_in_ready", in_ready, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_num_red", num_red, '0);
        check("rst_den_red", den_red, '0);
        check("rst_gcd", gcd_out, '0);
        check1("rst_err", err, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        check1("idle_in_ready", in_ready, 1'b1);

        send(48, 18, 8, 3, 6, 1'b0);
        receive("f48_18", MAXLAT, 1'b0, 0);

        send(0, 5, 0, 1, 5, 1'b0);
        receive("f0_5", 1, 1'b1, 0);

        send(7, 0, 0, 0, 0, 1'b1);
        receive("f7_0", 1, 1'b1, 0);

        send(17, 13, 17, 13, 1, 1'b0);
        receive("f17_13", 2 * W + 2, 1'b0, 0);

        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFF, 1'b0);
        receive("fmax", MAXLAT, 1'b0, 0);

        send(32'h8000_0000, 32'h4000_0000, 2, 1, 32'h4000_0000, 1'b0);
        receive("fpow2", MAXLAT, 1'b0, 0);

        send(100, 75, 4, 3, 25, 1'b0);
        receive("fbp", MAXLAT, 1'b0, 20);

        // 48/18 reaches the divide phase 7 cycles after transfer.
        send(48, 18, 8, 3, 6, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("mid_rst_out_valid", out_valid, 1'b0);
        check1("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_num_red", num_red, '0);
        check("mid_rst_den_red", den_red, '0);
        check("mid_rst_gcd", gcd_out, '0);
        reset = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) check1("post_rst_spurious", out_valid, 1'b0);
        end
        check1("post_rst_in_ready", in_ready, 1'b1);
        check1("post_rst_no_valid", out_valid, 1'b0);

        send(84, 36, 7, 3, 12, 1'b0);
        receive("f84_36", MAXLAT, 1'b0, 0);

        check("sb_empty", W'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
